// File: rtl/share_adjust_unit_pkg.sv
// Shared types and sizes for the share adjust unit.
// Optional refresh path is selected with SHARE_REFRESH_EN.
package share_adjust_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int NUM_SHARES = 4;
   localparam int SHARE_W    = 8;
   localparam int IDX_W      = 3;

   typedef logic [NUM_SHARES-1:0][SHARE_W-1:0] shares_t;

endpackage

// File: rtl/share_adjust_unit_refresh.sv
// Combinational re-randomisation of the two highest unused shares.
// Both touched shares take the same mask, so their XOR is unchanged.
module share_refresh_unit
   import share_adjust_unit_pkg::*;
(
   input  shares_t                 shares_i,
   input  logic [NUM_SHARES-1:0]   used_i,
   input  logic [SHARE_W-1:0]      r0_i,
   output shares_t                 shares_o
);

   logic [2:0] hits;

   always_comb begin
      shares_o = shares_i;
      hits     = 3'd0;
      if ($countones(~used_i) >= 2) begin
         for (int i = NUM_SHARES - 1; i >= 0; i--) begin
            if (!used_i[i] && hits < 3'd2) begin
               shares_o[i] = shares_i[i] ^ r0_i;
               hits        = hits + 3'd1;
            end
         end
      end
   end

endmodule

// File: rtl/share_adjust_unit.sv
// Masked byte split / fold / recombine unit (IDLE -> ACC -> DONE).
// Define SHARE_REFRESH_EN to compile in share refresh on refresh_en.
module share_adjust_unit
   import share_adjust_unit_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                divide_en,
   input  logic                adjust_en,
   input  logic [IDX_W-1:0]    adjust_idx,
   input  logic                refresh_en,
   input  logic                address_en,
   input  logic [SHARE_W-1:0]  x_in,
   input  logic [23:0]         rnd_in,
   output logic [SHARE_W-1:0]  addr_out,
   output logic                out_valid,
   output logic                busy,
   output logic                err
);

   state_e                  state_q, state_d;
   shares_t                 sh_q, sh_d;
   logic [SHARE_W-1:0]      acc_q, acc_d;
   logic [NUM_SHARES-1:0]   used_q, used_d;
   logic [SHARE_W-1:0]      addr_q, addr_d;
   logic                    ov_q, ov_d;
   logic                    err_q, err_d;

   logic [SHARE_W-1:0]      r0, r1, r2;
   logic [1:0]              sel;
   logic                    idx_legal;
   logic                    adj_ok;
   logic                    all_used;

   assign r0        = rnd_in[7:0];
   assign r1        = rnd_in[15:8];
   assign r2        = rnd_in[23:16];
   assign sel       = adjust_idx[1:0];
   assign idx_legal = adjust_idx < IDX_W'(NUM_SHARES);
   assign adj_ok    = idx_legal && !used_q[sel];
   assign all_used  = &used_q;

`ifdef SHARE_REFRESH_EN
   shares_t sh_ref;

   share_refresh_unit u_refresh (
      .shares_i (sh_q),
      .used_i   (used_q),
      .r0_i     (r0),
      .shares_o (sh_ref)
   );
`else
   logic unused_refresh;
   assign unused_refresh = refresh_en;
`endif

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      acc_d   = acc_q;
      used_d  = used_q;
      addr_d  = addr_q;
      ov_d    = 1'b0;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (divide_en) begin
               sh_d[0] = r0;
               sh_d[1] = r1;
               sh_d[2] = r2;
               sh_d[3] = x_in ^ r0 ^ r1 ^ r2;
               acc_d   = '0;
               used_d  = '0;
               state_d = ST_ACC;
            end
         end
         ST_ACC: begin
            // an early address request must not block the folds it waits on
            if (address_en && all_used) begin
               addr_d  = acc_q;
               ov_d    = 1'b1;
               state_d = ST_DONE;
            end else if (adjust_en) begin
               if (adj_ok) begin
                  acc_d       = acc_q ^ sh_q[sel];
                  used_d[sel] = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
`ifdef SHARE_REFRESH_EN
            end else if (refresh_en) begin
               sh_d = sh_ref;
`endif
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sh_q    <= '0;
         acc_q   <= '0;
         used_q  <= '0;
         addr_q  <= '0;
         ov_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         acc_q   <= acc_d;
         used_q  <= used_d;
         addr_q  <= addr_d;
         ov_q    <= ov_d;
         err_q   <= err_d;
      end
   end

   assign addr_out  = addr_q;
   assign out_valid = ov_q;
   assign busy      = (state_q == ST_ACC);
   assign err       = err_q;

endmodule
